switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter WIDTH, default 2: number of independent switch inputs.
REQ-002 Parameter DB_CYCLES, default 16: consecutive cycles an input must hold a new level before it is accepted; legal range 2..255.
REQ-003 clk  input  1: single system clock; all logic on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 switch  input  WIDTH: raw, asynchronous, bouncing switch levels.
REQ-006 sw_stable  output  WIDTH: debounced switch levels, registered.
REQ-007 sw_rise  output  WIDTH: one-cycle pulse per bit on an accepted 0->1 transition, registered.
REQ-008 sw_fall  output  WIDTH: one-cycle pulse per bit on an accepted 1->0 transition, registered.
REQ-009 sw_change  output  1: OR of all bits of sw_rise and sw_fall, in the same cycle.
REQ-010 rise_cnt  output  4: count of accepted rising transitions on bit 0, registered.

Function
REQ-011 Each switch bit SHALL pass through a two-flop synchronizer (sync1 then sync2) before any other use.
REQ-012 Each bit SHALL have a private 8-bit counter and SHALL be processed independently of the other bits.
REQ-013 Per-bit states: STABLE (sync2 == sw_stable, counter 0) and COUNTING (sync2 != sw_stable).
REQ-014 In STABLE, an edge with sync2 != sw_stable SHALL set the counter to 1 and enter COUNTING.
REQ-015 In COUNTING, an edge with sync2 == sw_stable SHALL clear the counter to 0 and return to STABLE (glitch rejected, no pulse).
REQ-016 In COUNTING, an edge with sync2 != sw_stable and counter < DB_CYCLES-1 SHALL increment the counter.
REQ-017 In COUNTING, an edge with sync2 != sw_stable and counter == DB_CYCLES-1 SHALL load sw_stable with sync2, clear the counter and return to STABLE.
REQ-018 On that accepting edge, the matching sw_rise or sw_fall bit SHALL go high for exactly one cycle, aligned with the cycle in which sw_stable first shows the new value.
REQ-019 sw_rise and sw_fall SHALL be 0 in every other cycle; a bit SHALL never assert both in the same cycle.
REQ-020 Latency: a clean step on switch SHALL appear on sw_stable after exactly DB_CYCLES+2 rising edges (2 for the synchronizer, DB_CYCLES for the filter).
REQ-021 Any input pulse or glitch that holds for at most DB_CYCLES-1 synchronized cycles SHALL leave sw_stable, sw_rise and sw_fall unchanged.
REQ-022 If several bits are accepted on the same edge, their pulses SHALL be simultaneous, and sw_change SHALL be a single one-cycle pulse.
REQ-023 rise_cnt SHALL increment by 1 in the cycle sw_rise[0] is high and SHALL wrap from 15 to 0 with no flag.
REQ-024 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.

Reset
REQ-025 While rst is high at a clock edge, sync1, sync2, per-bit counters, sw_stable, sw_rise, sw_fall, sw_change and rise_cnt SHALL all be set to 0.
REQ-026 Reset SHALL take priority over every transition, including an accepting edge in the same cycle.
REQ-027 Reset asserted mid-count SHALL discard the partial count; filtering SHALL restart from STABLE after release.
REQ-028 If switch is held nonzero through reset release, the bits SHALL be accepted as rising transitions DB_CYCLES+2 edges after release, with the normal pulses.

Verification (DB_CYCLES=16, WIDTH=2)
REQ-029 Reset, then switch 00->01 held steady -> sw_stable=01 and sw_rise=01 for one cycle on edge 18 after the change, sw_change=1, rise_cnt=1.
REQ-030 switch[0] glitch of 15 cycles, then back to 0 -> sw_stable stays 00 with no pulses; a 16-cycle hold -> accepted on edge 18.
REQ-031 switch 00->11 in one step -> both bits accepted on the same edge, sw_rise=11, one sw_change pulse; then 11->10 -> sw_fall=01 only.
REQ-032 Bounce pattern 1,0,1,0 (3 cycles each), then steady 1 -> a single sw_rise[0] pulse 18 edges after the final steady 1 begins.
REQ-033 Sixteen accepted rise/fall pairs on bit 0 -> rise_cnt sequence 1..15, then 0.
REQ-034 rst pulsed at counter value 10 with switch held at 01 -> all outputs 0, then acceptance 18 edges after rst is released.

Source files
------------

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - per-bit two-flop synchronized switch debouncer with edge pulses
module switch_debounce #(
  parameter int WIDTH     = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_change,
  output logic [3:0]       rise_cnt
);

  localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             change_q, change_d;
  logic [3:0]       rise_cnt_q, rise_cnt_d;
  logic [7:0]       cnt_q [WIDTH];
  logic [7:0]       cnt_d [WIDTH];

  // A bit is STABLE when its counter is zero and COUNTING otherwise; the
  // counter only leaves zero while sync2 disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] == 8'd0) begin
        if (sync2_q[i] != stable_q[i]) begin
          cnt_d[i] = 8'd1;
        end
      end else if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]    = 8'd0;
        stable_d[i] = sync2_q[i];
        rise_d[i]   = sync2_q[i];
        fall_d[i]   = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
    change_d   = (|rise_d) | (|fall_d);
    rise_cnt_d = rise_cnt_q + {3'b000, rise_d[0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      change_q   <= 1'b0;
      rise_cnt_q <= 4'd0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      sync1_q    <= switch;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      change_q   <= change_d;
      rise_cnt_q <= rise_cnt_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_stable = stable_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign sw_change = change_q;
  assign rise_cnt  = rise_cnt_q;

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - scoreboard bench for switch_debounce
module tb_switch_debounce;

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] stable;
    logic [3:0] rcnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] switch = 2'b00;
  logic [1:0] sw_stable, sw_rise, sw_fall;
  logic       sw_change;
  logic [3:0] rise_cnt;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [3:0] exp_rcnt = 4'd0;
  ev_t  exp_q[$];
  ev_t  m_e;

  switch_debounce #(.WIDTH(2), .DB_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .switch    (switch),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_change (sw_change),
    .rise_cnt  (rise_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse the DUT produces must match the oldest expected event.
  always @(negedge clk) begin
    if (sw_change || (|sw_rise) || (|sw_fall)) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b change=%b required no pulse",
                 cyc, sw_rise, sw_fall, sw_change);
      end else begin
        m_e = exp_q.pop_front();
        if (cyc !== m_e.cyc || sw_rise !== m_e.rise || sw_fall !== m_e.fall ||
            sw_stable !== m_e.stable || rise_cnt !== m_e.rcnt || sw_change !== 1'b1) begin
          $display("FAIL pulse_event got cyc=%0d rise=%b fall=%b stable=%b rcnt=%0d change=%b required cyc=%0d rise=%b fall=%b stable=%b rcnt=%0d change=1",
                   cyc, sw_rise, sw_fall, sw_stable, rise_cnt, sw_change,
                   m_e.cyc, m_e.rise, m_e.fall, m_e.stable, m_e.rcnt);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [1:0] r, input logic [1:0] f,
                           input logic [1:0] s);
    ev_t e;
    if (r[0]) exp_rcnt = exp_rcnt + 4'd1;
    e.cyc = c; e.rise = r; e.fall = f; e.stable = s; e.rcnt = exp_rcnt;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    switch = 2'b11;
    tick(3);
    n_total++;
    if ({sw_stable, sw_rise, sw_fall, sw_change, rise_cnt} !== 11'd0)
      $display("FAIL reset_outputs got stable=%b rise=%b fall=%b change=%b rcnt=%0d required all 0",
               sw_stable, sw_rise, sw_fall, sw_change, rise_cnt);
    else n_pass++;
    switch = 2'b00;
    rst = 1'b0;
    exp_rcnt = 4'd0;
    tick(25);
    n_total++;
    if (sw_stable !== 2'b00) $display("FAIL reset_idle got stable=%b required 00", sw_stable);
    else n_pass++;
  endtask

  task automatic test_single_rise();
    int t;
    t = cyc;
    switch = 2'b01;
    expect_ev(t + 18, 2'b01, 2'b00, 2'b01);
    tick(17);
    n_total++;
    if (sw_stable !== 2'b00) $display("FAIL latency_early got stable=%b required 00", sw_stable);
    else n_pass++;
    tick(1);
    n_total++;
    if (sw_stable !== 2'b01 || sw_rise !== 2'b01)
      $display("FAIL latency_edge18 got stable=%b rise=%b required 01 01", sw_stable, sw_rise);
    else n_pass++;
    tick(1);
    n_total++;
    if (sw_rise !== 2'b00 || sw_change !== 1'b0)
      $display("FAIL pulse_width got rise=%b change=%b required 00 0", sw_rise, sw_change);
    else n_pass++;
    t = cyc;
    switch = 2'b00;
    expect_ev(t + 18, 2'b00, 2'b01, 2'b00);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick(1);
    n_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_single got pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_glitch();
    int t;
    t = cyc;
    switch = 2'b01;
    tick(15);
    switch = 2'b00;
    tick(30);
    n_total++;
    if (sw_stable !== 2'b00) $display("FAIL glitch15 got stable=%b required 00", sw_stable);
    else n_pass++;
    t = cyc;
    switch = 2'b01;
    expect_ev(t + 18, 2'b01, 2'b00, 2'b01);
    tick(16);
    switch = 2'b00;
    expect_ev(t + 34, 2'b00, 2'b01, 2'b00);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick(1);
    n_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_glitch got pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_both_bits();
    int t;
    t = cyc;
    switch = 2'b11;
    expect_ev(t + 18, 2'b11, 2'b00, 2'b11);
    tick(25);
    t = cyc;
    switch = 2'b10;
    expect_ev(t + 18, 2'b00, 2'b01, 2'b10);
    tick(25);
    t = cyc;
    switch = 2'b00;
    expect_ev(t + 18, 2'b00, 2'b10, 2'b00);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick(1);
    n_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_both got pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_bounce();
    int t;
    for (int k = 0; k < 4; k++) begin
      switch = (k % 2 == 0) ? 2'b01 : 2'b00;
      tick(3);
    end
    t = cyc;
    switch = 2'b01;
    expect_ev(t + 18, 2'b01, 2'b00, 2'b01);
    tick(25);
    t = cyc;
    switch = 2'b00;
    expect_ev(t + 18, 2'b00, 2'b01, 2'b00);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick(1);
    n_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_bounce got pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_reset_mid_count();
    int t;
    t = cyc;
    switch = 2'b01;
    tick(12);
    rst = 1'b1;
    tick(1);
    exp_rcnt = 4'd0;
    n_total++;
    if ({sw_stable, sw_rise, sw_fall, sw_change, rise_cnt} !== 11'd0)
      $display("FAIL reset_mid_outputs got stable=%b rcnt=%0d required 00 0", sw_stable, rise_cnt);
    else n_pass++;
    rst = 1'b0;
    t = cyc;
    expect_ev(t + 18, 2'b01, 2'b00, 2'b01);
    tick(17);
    n_total++;
    if (sw_stable !== 2'b00) $display("FAIL reset_mid_early got stable=%b required 00", sw_stable);
    else n_pass++;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick(1);
    n_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_reset_mid got pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    // Reset landing exactly on the accepting edge of the falling transition.
    t = cyc;
    switch = 2'b00;
    tick(17);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_rcnt = 4'd0;
    tick(30);
    n_total++;
    if (sw_stable !== 2'b00 || rise_cnt !== 4'd0)
      $display("FAIL reset_priority got stable=%b rcnt=%0d required 00 0", sw_stable, rise_cnt);
    else n_pass++;
  endtask

  task automatic test_rise_cnt_wrap();
    int t;
    rst = 1'b1;
    switch = 2'b00;
    tick(2);
    rst = 1'b0;
    exp_rcnt = 4'd0;
    for (int k = 0; k < 16; k++) begin
      t = cyc;
      switch = 2'b01;
      expect_ev(t + 18, 2'b01, 2'b00, 2'b01);
      tick(20);
      t = cyc;
      switch = 2'b00;
      expect_ev(t + 18, 2'b00, 2'b01, 2'b00);
      tick(20);
    end
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick(1);
    n_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_wrap got pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    n_total++;
    if (rise_cnt !== exp_rcnt) $display("FAIL rise_cnt_wrap got %0d required %0d", rise_cnt, exp_rcnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_both_bits();
    test_bounce();
    test_reset_mid_count();
    test_rise_cnt_wrap();
    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d required completion", cyc);
    $fatal(1);
  end

endmodule
